// File: rtl/grey_int_ctrl_pkg.sv
// Shared constants for the grey-statistics interrupt sequencer:
// the FSM state encoding and the default minimum interrupt-pin width.
package grey_stat_pkg;

  localparam int INT_MIN_WIDTH_DEF = 16;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FRAME     = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_INT       = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;

endpackage

// File: rtl/grey_int_ctrl_if.sv
// Frame-timing, statistics and interrupt signals of the grey-statistics sequencer.
// The master side drives frame timing and firmware strobes; the slave is the sequencer.
interface grey_int_ctrl_if #(
  parameter int TIMEOUT_WIDTH = 24,
  parameter int CNT_WIDTH     = 16
);
  logic                     i_fval;
  logic                     i_interrupt_en;
  logic                     i_stat_done;
  logic                     i_int_clr;
  logic [TIMEOUT_WIDTH-1:0] iv_timeout;
  logic                     o_interrupt_pin;
  logic                     o_stat_clear;
  logic                     o_busy;
  logic [CNT_WIDTH-1:0]     ov_frame_cnt;
  logic [CNT_WIDTH-1:0]     ov_miss_cnt;

  modport master (
    output i_fval, i_interrupt_en, i_stat_done, i_int_clr, iv_timeout,
    input  o_interrupt_pin, o_stat_clear, o_busy, ov_frame_cnt, ov_miss_cnt
  );

  modport slave (
    input  i_fval, i_interrupt_en, i_stat_done, i_int_clr, iv_timeout,
    output o_interrupt_pin, o_stat_clear, o_busy, ov_frame_cnt, ov_miss_cnt
  );
endinterface

// File: rtl/grey_int_ctrl.sv
// Grey-statistics interrupt sequencer for the 2A path: clears accumulators at frame
// start, raises and holds the interrupt pin until firmware clears it, counts lost frames.
//
// state       | meaning
// S_IDLE      | waiting for a frame-valid rise
// S_FRAME     | frame in progress, accumulating
// S_WAIT_DONE | frame ended, waiting for statistics done or timeout
// S_INT       | pin high, minimum pin width not yet served
// S_HOLD      | pin high, waiting for firmware clear
module grey_int_ctrl
  import grey_stat_pkg::*;
#(
  parameter int INT_MIN_WIDTH = INT_MIN_WIDTH_DEF,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int CNT_WIDTH     = 16
) (
  input  logic            clk,
  input  logic            reset,
  grey_int_ctrl_if.slave  bus
);

  localparam int WW = $clog2(INT_MIN_WIDTH + 1);
  localparam logic [WW-1:0] WIDTH_LAST = WW'(INT_MIN_WIDTH - 1);

  logic [2:0]               state_q, state_d;
  logic                     fval_dly_q;
  logic                     en_dly_q;
  logic [WW-1:0]            width_q, width_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic                     pend_q, pend_d;
  logic                     clear_q, clear_d;
  logic [CNT_WIDTH-1:0]     frame_cnt_q;
  logic [CNT_WIDTH-1:0]     miss_cnt_q;
  logic                     frame_inc, miss_inc;
  logic                     rise, fall, en_fall, tmo_expire;

  assign rise       = bus.i_fval & ~fval_dly_q;
  assign fall       = ~bus.i_fval & fval_dly_q;
  assign en_fall    = en_dly_q & ~bus.i_interrupt_en;
  assign tmo_expire = (bus.iv_timeout != '0) &&
                      (tmo_q == bus.iv_timeout - TIMEOUT_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    tmo_d     = tmo_q;
    pend_d    = pend_q;
    clear_d   = 1'b0;
    frame_inc = 1'b0;
    miss_inc  = 1'b0;
    if (en_fall) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            clear_d = 1'b1;
            state_d = S_FRAME;
          end
        end
        S_FRAME: begin
          if (fall) begin
            state_d = S_WAIT_DONE;
            tmo_d   = '0;
          end
        end
        S_WAIT_DONE: begin
          tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
          // done outranks both a new frame and timeout expiry
          if (bus.i_stat_done) begin
            if (bus.i_interrupt_en) begin
              state_d   = S_INT;
              width_d   = '0;
              frame_inc = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else if (rise) begin
            miss_inc = 1'b1;
            clear_d  = 1'b1;
            state_d  = S_FRAME;
          end else if (tmo_expire) begin
            miss_inc = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_INT: begin
          width_d  = width_q + WW'(1);
          miss_inc = rise;
          if (bus.i_int_clr) pend_d = 1'b1;
          if (width_q == WIDTH_LAST) begin
            state_d = (pend_q | bus.i_int_clr) ? S_IDLE : S_HOLD;
          end
        end
        S_HOLD: begin
          miss_inc = rise;
          if (bus.i_int_clr) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d != S_INT) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fval_dly_q  <= 1'b0;
      en_dly_q    <= 1'b0;
      width_q     <= '0;
      tmo_q       <= '0;
      pend_q      <= 1'b0;
      clear_q     <= 1'b0;
      frame_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      fval_dly_q <= bus.i_fval;
      en_dly_q   <= bus.i_interrupt_en;
      width_q    <= width_d;
      tmo_q      <= tmo_d;
      pend_q     <= pend_d;
      clear_q    <= clear_d;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
      if (miss_inc && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.o_interrupt_pin = (state_q == S_INT) || (state_q == S_HOLD);
  assign bus.o_busy          = (state_q != S_IDLE);
  assign bus.o_stat_clear    = clear_q;
  assign bus.ov_frame_cnt    = frame_cnt_q;
  assign bus.ov_miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_grey_int_ctrl.sv
// Scenario bench for grey_int_ctrl: directed edge cases plus randomized frames
// checked against an event-level model of interrupt, clear and miss counts.
module tb_grey_int_ctrl;
  localparam int TW  = 24;
  localparam int CW  = 6;
  localparam int IMW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grey_int_ctrl_if #(.TIMEOUT_WIDTH(TW), .CNT_WIDTH(CW)) bus ();
  grey_int_ctrl #(.INT_MIN_WIDTH(IMW), .TIMEOUT_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_miss = 0;
  int pin_hi = 0;
  int clr_seen = 0;

  always @(negedge clk) begin
    if (bus.o_interrupt_pin === 1'b1) pin_hi++;
    if (bus.o_stat_clear === 1'b1) clr_seen++;
  end

  function automatic int sat_miss();
    return (exp_miss > CMAX) ? CMAX : exp_miss;
  endfunction

  function automatic int wrap_frames();
    return exp_frames % (CMAX + 1);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // fval high for fl cycles; returns just after the edge that samples the fall
  task automatic do_frame(input int fl);
    bus.i_fval = 1'b1; tick(fl);
    bus.i_fval = 1'b0; tick(1);
  endtask

  task automatic done_after(input int g);
    tick(g - 1); bus.i_stat_done = 1'b1; tick(1); bus.i_stat_done = 1'b0;
  endtask

  task automatic clr_after(input int k);
    tick(k - 1); bus.i_int_clr = 1'b1; tick(1); bus.i_int_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_fval = 0; bus.i_interrupt_en = 1; bus.i_stat_done = 0; bus.i_int_clr = 0;
    bus.iv_timeout = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++; if (bus.o_interrupt_pin !== 1'b0) begin errors++; $display("FAIL reset_pin got %b want 0", bus.o_interrupt_pin); end
    checks++; if (bus.o_stat_clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", bus.o_stat_clear); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    checks++; if (bus.ov_frame_cnt !== '0) begin errors++; $display("FAIL reset_frame got %0d want 0", bus.ov_frame_cnt); end
    checks++; if (bus.ov_miss_cnt !== '0) begin errors++; $display("FAIL reset_miss got %0d want 0", bus.ov_miss_cnt); end
  endtask

  task automatic test_basic();
    int p0, c0;
    p0 = pin_hi; c0 = clr_seen;
    do_frame(100);
    tick(4);
    checks++; if (bus.o_interrupt_pin !== 1'b0) begin errors++; $display("FAIL basic_pin_before_done got %b want 0", bus.o_interrupt_pin); end
    done_after(1); exp_frames++;
    checks++; if (bus.o_interrupt_pin !== 1'b1) begin errors++; $display("FAIL basic_pin_rise got %b want 1", bus.o_interrupt_pin); end
    checks++; if (int'(bus.ov_frame_cnt) !== wrap_frames()) begin errors++; $display("FAIL basic_frame got %0d want %0d", bus.ov_frame_cnt, wrap_frames()); end
    clr_after(41);
    checks++; if (bus.o_interrupt_pin !== 1'b0) begin errors++; $display("FAIL basic_pin_drop got %b want 0", bus.o_interrupt_pin); end
    tick(2);
    checks++; if (pin_hi - p0 !== 41) begin errors++; $display("FAIL basic_pin_width got %0d want 41", pin_hi - p0); end
    checks++; if (clr_seen - c0 !== 1) begin errors++; $display("FAIL basic_clear_pulses got %0d want 1", clr_seen - c0); end
    checks++; if (int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL basic_miss got %0d want %0d", bus.ov_miss_cnt, sat_miss()); end
  endtask

  task automatic test_early_clear();
    int p0;
    p0 = pin_hi;
    do_frame(8);
    done_after(2); exp_frames++;
    clr_after(3);
    tick(12);
    checks++; if (bus.o_interrupt_pin !== 1'b1) begin errors++; $display("FAIL early_pin_last got %b want 1", bus.o_interrupt_pin); end
    tick(1);
    checks++; if (bus.o_interrupt_pin !== 1'b0) begin errors++; $display("FAIL early_pin_drop got %b want 0", bus.o_interrupt_pin); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL early_idle got busy %b want 0", bus.o_busy); end
    tick(2);
    checks++; if (pin_hi - p0 !== IMW) begin errors++; $display("FAIL early_pin_width got %0d want %0d", pin_hi - p0, IMW); end
  endtask

  task automatic test_timeout();
    int p0;
    p0 = pin_hi;
    bus.iv_timeout = TW'(50);
    do_frame(10);
    tick(49);
    checks++; if (bus.o_busy !== 1'b1 || int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL tmo_before busy %b miss %0d want 1 %0d", bus.o_busy, bus.ov_miss_cnt, sat_miss()); end
    tick(1); exp_miss++;
    checks++; if (int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL tmo_miss got %0d want %0d", bus.ov_miss_cnt, sat_miss()); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got busy %b want 0", bus.o_busy); end
    checks++; if (pin_hi - p0 !== 0) begin errors++; $display("FAIL tmo_pin got %0d high cycles want 0", pin_hi - p0); end
    bus.i_fval = 1'b1; tick(1);
    checks++; if (bus.o_stat_clear !== 1'b1) begin errors++; $display("FAIL tmo_next_clear got %b want 1", bus.o_stat_clear); end
    bus.i_fval = 1'b0; tick(1);
    done_after(50); exp_frames++;  // done on the expiry cycle itself
    checks++; if (bus.o_interrupt_pin !== 1'b1 || int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL tmo_done_wins pin %b miss %0d want 1 %0d", bus.o_interrupt_pin, bus.ov_miss_cnt, sat_miss()); end
    clr_after(20); tick(2);
    bus.iv_timeout = '0;
  endtask

  task automatic test_busy_frame();
    int c0, p0;
    p0 = pin_hi;
    do_frame(5);
    done_after(3); exp_frames++;
    c0 = clr_seen;
    tick(4);
    bus.i_fval = 1'b1; tick(1); exp_miss++;
    tick(6);
    bus.i_fval = 1'b0; tick(1);
    checks++; if (int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL busy_miss got %0d want %0d", bus.ov_miss_cnt, sat_miss()); end
    checks++; if (clr_seen - c0 !== 0) begin errors++; $display("FAIL busy_clear_suppressed got %0d pulses want 0", clr_seen - c0); end
    checks++; if (bus.o_interrupt_pin !== 1'b1) begin errors++; $display("FAIL busy_pin_held got %b want 1", bus.o_interrupt_pin); end
    clr_after(15); tick(2);
    checks++; if (pin_hi - p0 !== 27) begin errors++; $display("FAIL busy_pin_width got %0d want 27", pin_hi - p0); end
    do_frame(6);
    checks++; if (clr_seen - c0 !== 1) begin errors++; $display("FAIL busy_next_clear got %0d pulses want 1", clr_seen - c0); end
    done_after(2); exp_frames++;
    checks++; if (int'(bus.ov_frame_cnt) !== wrap_frames()) begin errors++; $display("FAIL busy_next_frame got %0d want %0d", bus.ov_frame_cnt, wrap_frames()); end
    clr_after(1); tick(18);
  endtask

  task automatic test_clr_with_rise();
    int c0;
    do_frame(4);
    done_after(1); exp_frames++;
    tick(20);
    c0 = clr_seen;
    bus.i_fval = 1'b1; bus.i_int_clr = 1'b1; tick(1); bus.i_int_clr = 1'b0; exp_miss++;
    checks++; if (bus.o_interrupt_pin !== 1'b0 || int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL clrrise pin %b miss %0d want 0 %0d", bus.o_interrupt_pin, bus.ov_miss_cnt, sat_miss()); end
    tick(3);
    checks++; if (bus.o_busy !== 1'b0 || clr_seen - c0 !== 0) begin errors++; $display("FAIL clrrise_no_redetect busy %b clears %0d want 0 0", bus.o_busy, clr_seen - c0); end
    bus.i_fval = 1'b0; tick(2);
  endtask

  task automatic test_enable_drop();
    do_frame(4);
    done_after(2); exp_frames++;
    tick(20);
    bus.i_interrupt_en = 1'b0; tick(1);
    checks++; if (bus.o_interrupt_pin !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL endrop pin %b busy %b want 0 0", bus.o_interrupt_pin, bus.o_busy); end
    checks++; if (int'(bus.ov_frame_cnt) !== wrap_frames() || int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL endrop_counts frame %0d miss %0d want %0d %0d", bus.ov_frame_cnt, bus.ov_miss_cnt, wrap_frames(), sat_miss()); end
    tick(1); bus.i_interrupt_en = 1'b1; tick(2);
    bus.i_int_clr = 1'b1; tick(1); bus.i_int_clr = 1'b0; tick(1);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL idle_clr_ignored busy %b want 0", bus.o_busy); end
  endtask

  task automatic test_random();
    int mode, fl, g, k, t, c0, p0, w;
    for (int it = 0; it < 70; it++) begin
      tick($urandom_range(1, 3));
      mode = $urandom_range(0, 4);
      fl = $urandom_range(1, 20);
      c0 = clr_seen; p0 = pin_hi;
      if (mode == 0) begin
        t = $urandom_range(1, 20);
        bus.iv_timeout = TW'(t);
        do_frame(fl);
        tick(t - 1);
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rnd%0d_tmo_wait busy %b want 1", it, bus.o_busy); end
        tick(1); exp_miss++;
        checks++; if (bus.o_busy !== 1'b0 || int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL rnd%0d_tmo busy %b miss %0d want 0 %0d", it, bus.o_busy, bus.ov_miss_cnt, sat_miss()); end
        tick(2);
        w = 0;
      end else begin
        g = $urandom_range(1, 10);
        k = $urandom_range(1, 30);
        bus.iv_timeout = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(g, 40));
        do_frame(fl);
        done_after(g); exp_frames++;
        checks++; if (bus.o_interrupt_pin !== 1'b1) begin errors++; $display("FAIL rnd%0d_pin_rise got %b want 1", it, bus.o_interrupt_pin); end
        clr_after(k);
        tick(18);
        w = (k > IMW) ? k : IMW;
      end
      checks++; if (pin_hi - p0 !== w || clr_seen - c0 !== 1) begin errors++; $display("FAIL rnd%0d_pulses pin %0d clears %0d want %0d 1", it, pin_hi - p0, clr_seen - c0, w); end
      checks++; if (int'(bus.ov_frame_cnt) !== wrap_frames() || int'(bus.ov_miss_cnt) !== sat_miss() || bus.o_busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_counts frame %0d miss %0d busy %b want %0d %0d 0", it, bus.ov_frame_cnt, bus.ov_miss_cnt, bus.o_busy, wrap_frames(), sat_miss()); end
    end
    bus.iv_timeout = '0;
  endtask

  task automatic test_reset_mid_int();
    do_frame(6);
    done_after(2);
    tick(3);
    reset = 1'b1; tick(1); reset = 1'b0;
    exp_frames = 0; exp_miss = 0;
    checks++; if (bus.o_interrupt_pin !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_stat_clear !== 1'b0) begin errors++; $display("FAIL rstint pin %b busy %b clear %b want 0 0 0", bus.o_interrupt_pin, bus.o_busy, bus.o_stat_clear); end
    checks++; if (bus.ov_frame_cnt !== '0 || bus.ov_miss_cnt !== '0) begin errors++; $display("FAIL rstint_counts frame %0d miss %0d want 0 0", bus.ov_frame_cnt, bus.ov_miss_cnt); end
    tick(2);
  endtask

  // each fval pulse after the first lands in S_WAIT_DONE and abandons the stale frame
  task automatic test_saturation();
    bus.iv_timeout = '0;
    for (int i = 0; i < 63; i++) begin
      bus.i_fval = 1'b1; tick(1); bus.i_fval = 1'b0; tick(1);
      if (i > 0) exp_miss++;
    end
    checks++; if (int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL sat_below got %0d want %0d", bus.ov_miss_cnt, sat_miss()); end
    for (int i = 0; i < 5; i++) begin
      bus.i_fval = 1'b1; tick(1); bus.i_fval = 1'b0; tick(1);
      exp_miss++;
    end
    checks++; if (int'(bus.ov_miss_cnt) !== sat_miss()) begin errors++; $display("FAIL sat_hold got %0d want %0d", bus.ov_miss_cnt, sat_miss()); end
    bus.i_interrupt_en = 1'b0; tick(1); bus.i_interrupt_en = 1'b1; tick(1);
    checks++; if (bus.o_busy !== 1'b0 || int'(bus.ov_frame_cnt) !== wrap_frames()) begin errors++; $display("FAIL sat_exit busy %b frame %0d want 0 %0d", bus.o_busy, bus.ov_frame_cnt, wrap_frames()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_clear();
    test_timeout();
    test_busy_frame();
    test_clr_with_rise();
    test_enable_drop();
    test_random();
    test_reset_mid_int();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
